// File: rtl/mult_8_booth_pkg.sv
// rtl/mult_8_booth_pkg.sv - shared arithmetic definitions for the ALU blocks
package mult_8_booth_pkg;

  // Sequencer states for the iterative multiplier
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } booth_state_t;

  // Number of radix-2 Booth steps for an 8-bit operand
  localparam int BOOTH_ITERATIONS = 8;

endpackage

// File: rtl/mult_8_booth_addsub.sv
// rtl/mult_8_booth_addsub.sv - accumulator add/subtract for the Booth step
module booth_addsub_9 #(
  parameter int W = 9
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] s
);

  // Subtract is a + ~b + 1; the result wraps modulo 2^W
  assign s = a + (sub ? ~b : b) + {{(W-1){1'b0}}, sub};

endmodule

// File: rtl/mult_8_booth.sv
// rtl/mult_8_booth.sv - radix-2 Booth iterative signed multiplier
module mult_8_booth
  import mult_8_booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_ITERATIONS
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               ready,
  output logic               ovf
);

  // One guard bit in the accumulator keeps -M representable when M is the most negative value
  localparam int ACC_W = WIDTH + 1;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WIDTH - 1);

  booth_state_t state_q, state_d;

  logic [ACC_W-1:0]   a_reg;
  logic [WIDTH-1:0]   q_reg;
  logic               q_m1;
  logic [WIDTH-1:0]   m_reg;
  logic [CNT_W-1:0]   count;

  logic               do_add;
  logic               do_sub;
  logic [ACC_W-1:0]   m_ext;
  logic [ACC_W-1:0]   sum;
  logic [ACC_W-1:0]   a_step;
  logic [ACC_W-1:0]   a_shift;
  logic [WIDTH-1:0]   q_shift;
  logic [2*WIDTH-1:0] prod_next;
  logic               ovf_next;
  logic               last_step;

  assign m_ext     = {m_reg[WIDTH-1], m_reg};
  assign last_step = (count == LAST_COUNT);

  // Decode the Booth pair {Q0, Q-1} into add / subtract / hold
  always_comb begin
    do_add = 1'b0;
    do_sub = 1'b0;
    case ({q_reg[0], q_m1})
      2'b01:   do_add = 1'b1;
      2'b10:   do_sub = 1'b1;
      default: ;
    endcase
  end

  booth_addsub_9 #(.W(ACC_W)) u_addsub (
    .a   (a_reg),
    .b   (m_ext),
    .sub (do_sub),
    .s   (sum)
  );

  // Apply the selected step, then arithmetic-shift {A,Q,Q-1} right by one
  always_comb begin
    a_step    = (do_add || do_sub) ? sum : a_reg;
    a_shift   = {a_step[ACC_W-1], a_step[ACC_W-1:1]};
    q_shift   = {a_step[0], q_reg[WIDTH-1:1]};
    prod_next = {a_shift[WIDTH-1:0], q_shift};
    ovf_next  = !((&prod_next[2*WIDTH-1:WIDTH-1]) || (~|prod_next[2*WIDTH-1:WIDTH-1]));
  end

  // Next-state logic: IDLE waits for start, RUN counts WIDTH steps, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (last_step) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Datapath and registered status outputs; operands are captured only when a multiply starts
  always_ff @(posedge clock) begin
    if (reset) begin
      a_reg   <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      m_reg   <= '0;
      count   <= '0;
      product <= '0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      ready   <= 1'b0;
    end else begin
      busy  <= (state_d == ST_RUN);
      ready <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_reg <= '0;
            q_reg <= multiplier;
            q_m1  <= 1'b0;
            m_reg <= multiplicand;
            count <= '0;
          end
        end
        ST_RUN: begin
          a_reg <= a_shift;
          q_reg <= q_shift;
          q_m1  <= q_reg[0];
          count <= count + 1'b1;
          if (last_step) begin
            product <= prod_next;
            ovf     <= ovf_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_8_booth.sv
// tb/tb_mult_8_booth.sv - directed and random checks for mult_8_booth
module tb_mult_8_booth;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  multiplicand;
  logic [7:0]  multiplier;
  logic [15:0] product;
  logic        busy;
  logic        ready;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  mult_8_booth #(.WIDTH(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .ready        (ready),
    .ovf          (ovf)
  );

  always #5 clock = ~clock;

  // Issue one multiply from the next IDLE cycle and wait (bounded) for ready
  task automatic do_mult(input logic [7:0] m, input logic [7:0] q, input bit rel,
                         output logic [15:0] p, output logic o, output int lat, output int busy_cnt);
    @(negedge clock);
    if (rel) reset = 1'b0;
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(negedge clock);
    start    = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    p        = 'x;
    o        = 1'bx;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (busy) busy_cnt++;
      if (ready) begin
        lat = cyc;
        p   = product;
        o   = ovf;
        break;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    multiplicand = 8'd0;
    multiplier   = 8'd0;
    repeat (3) @(negedge clock);
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL reset_product actual=%h expected=0000", product); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf actual=%b expected=0", ovf); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b expected=0", busy); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready actual=%b expected=0", ready); end
  endtask

  task automatic test_basic;
    logic [15:0] p; logic o; int lat, bc;
    do_mult(8'd3, 8'd5, 1'b1, p, o, lat, bc);
    checks++; if (lat !== 9) begin errors++; $display("FAIL basic_latency actual=%0d expected=9", lat); end
    checks++; if (bc !== 8) begin errors++; $display("FAIL basic_busy_cycles actual=%0d expected=8", bc); end
    checks++; if (p !== 16'h000F) begin errors++; $display("FAIL basic_product actual=%h expected=000f", p); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL basic_ovf actual=%b expected=0", o); end
    @(negedge clock);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL basic_ready_pulse actual=%b expected=0", ready); end
    checks++; if (product !== 16'h000F) begin errors++; $display("FAIL basic_product_hold actual=%h expected=000f", product); end
  endtask

  task automatic test_corner;
    logic [15:0] p; logic o; int lat, bc;
    do_mult(8'h80, 8'h80, 1'b0, p, o, lat, bc);
    checks++; if (p !== 16'h4000) begin errors++; $display("FAIL min_min_product actual=%h expected=4000", p); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL min_min_ovf actual=%b expected=1", o); end
  endtask

  task automatic test_signs;
    logic [15:0] p; logic o; int lat, bc;
    do_mult(8'hFF, 8'h01, 1'b0, p, o, lat, bc);
    checks++; if (p !== 16'hFFFF) begin errors++; $display("FAIL neg1_product actual=%h expected=ffff", p); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL neg1_ovf actual=%b expected=0", o); end
    do_mult(8'h7F, 8'h80, 1'b0, p, o, lat, bc);
    checks++; if (p !== 16'hC080) begin errors++; $display("FAIL max_min_product actual=%h expected=c080", p); end
    checks++; if (o !== 1'b1) begin errors++; $display("FAIL max_min_ovf actual=%b expected=1", o); end
  endtask

  task automatic test_start_ignored;
    int rdy_cnt = 0;
    logic [15:0] p = 'x;
    @(negedge clock);
    multiplicand = 8'd2; multiplier = 8'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    multiplicand = 8'd9; multiplier = 8'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (ready) begin rdy_cnt++; p = product; end
      @(negedge clock);
    end
    checks++; if (rdy_cnt !== 1) begin errors++; $display("FAIL ignore_start_ready_count actual=%0d expected=1", rdy_cnt); end
    checks++; if (p !== 16'h0006) begin errors++; $display("FAIL ignore_start_product actual=%h expected=0006", p); end
  endtask

  task automatic test_reset_abort;
    int rdy_cnt = 0;
    logic [15:0] p; logic o; int lat, bc;
    @(negedge clock);
    multiplicand = 8'd5; multiplier = 8'd5; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (product !== 16'h0000) begin errors++; $display("FAIL abort_product actual=%h expected=0000", product); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy actual=%b expected=0", busy); end
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (ready) rdy_cnt++;
      @(negedge clock);
    end
    checks++; if (rdy_cnt !== 0) begin errors++; $display("FAIL abort_ready_count actual=%0d expected=0", rdy_cnt); end
    do_mult(8'd7, 8'hFA, 1'b0, p, o, lat, bc);
    checks++; if (p !== 16'hFFD6) begin errors++; $display("FAIL after_abort_product actual=%h expected=ffd6", p); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL after_abort_ovf actual=%b expected=0", o); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] p; logic o; int lat, bc;
    logic [7:0] m, q;
    int e;
    logic [15:0] exp_p;
    logic exp_o;
    for (int n = 0; n < 200; n++) begin
      m = 8'($urandom_range(0, 255));
      q = 8'($urandom_range(0, 255));
      e = $signed(m) * $signed(q);
      exp_p = e[15:0];
      exp_o = (e > 127) || (e < -128);
      do_mult(m, q, 1'b0, p, o, lat, bc);
      checks++; if (p !== exp_p) begin errors++; $display("FAIL rand_product m=%h q=%h actual=%h expected=%h", m, q, p, exp_p); end
      checks++; if (o !== exp_o) begin errors++; $display("FAIL rand_ovf m=%h q=%h actual=%b expected=%b", m, q, o, exp_o); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL rand_latency m=%h q=%h actual=%0d expected=9", m, q, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corner();
    test_signs();
    test_start_ignored();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_8_booth.md
MULT_8_BOOTH -- requirements
Module: mult_8_booth

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width; product width SHALL be 2*WIDTH; only 8 is required to be verified.
REQ-002 The block SHALL have port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port multiplicand, input, 8 bits: signed two's-complement operand M; sampled with start.
REQ-006 The block SHALL have port multiplier, input, 8 bits: signed two's-complement operand Q; sampled with start.
REQ-007 The block SHALL have port product, output, 16 bits: signed result register, held until the next completion.
REQ-008 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-009 The block SHALL have port ready, output, 1 bit: one-cycle pulse in DONE, marking product and ovf valid.
REQ-010 The block SHALL have port ovf, output, 1 bit: high when product is not representable as a signed 8-bit value; registered with product.

Function
REQ-011 The block SHALL implement states IDLE, RUN and DONE as a radix-2 Booth iterative multiplier.
REQ-012 In IDLE with start=1, the next edge SHALL load A(9-bit)=0, Qreg=multiplier, q_m1=0, Mreg=multiplicand and count=0, and enter RUN.
REQ-013 In IDLE with start=0, the state SHALL remain IDLE with no register changes.
REQ-014 Each RUN edge SHALL select the step from {Qreg[0],q_m1}: 01 gives A=A+sext(M); 10 gives A=A-sext(M); 00 and 11 leave A unchanged.
REQ-015 After the step of REQ-014, the same edge SHALL arithmetic-shift {A,Qreg,q_m1} right by one and increment count.
REQ-016 The 9-bit accumulator SHALL prevent intermediate overflow, including for M=-128; the add and subtract SHALL be modulo 2^9.
REQ-017 The block SHALL perform exactly 8 RUN steps; the edge executing step 8 (count==7) SHALL also write product={A[7:0],Qreg}, compute ovf, and enter DONE.
REQ-018 ovf SHALL equal 1 when product[15:7] is neither all zeros nor all ones.
REQ-019 DONE SHALL last exactly one cycle with ready=1, then return to IDLE.
REQ-020 Latency SHALL be fixed: if start is sampled at edge N, busy=1 during cycles N+1..N+8 and ready=1 during cycle N+9 only.
REQ-021 start SHALL be ignored in RUN and DONE; operand changes during RUN SHALL NOT affect the result.
REQ-022 product and ovf SHALL change only on the edge entering DONE (or on reset).
REQ-023 Back-to-back use SHALL be supported: start asserted in the IDLE cycle after DONE SHALL begin a new multiply.

Reset
REQ-024 With reset=1 at an edge, the block SHALL set state=IDLE, product=0, ovf=0, busy=0, ready=0, A=0, Qreg=0, q_m1=0, Mreg=0 and count=0.
REQ-025 Reset SHALL take priority over start and over any RUN or DONE activity.
REQ-026 Reset mid-operation SHALL abort the multiply without a ready pulse and with product=0.
REQ-027 The block SHALL accept start on the first edge after reset is released.

Structure
REQ-028 State encodings (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the iteration count constant 8 SHALL reside in the shared arithmetic definitions file used by the ALU blocks.
REQ-029 The 9-bit add/subtract SHALL be a single sub-module, booth_addsub_9 (inputs a, b, sub; output s), computing a+b or a+~b+1; the FSM, counter and shift register SHALL stay in mult_8_booth.
REQ-030 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.

Verification
REQ-031 Test: M=3, Q=5, start pulse -> busy for 8 cycles, ready 9 cycles after the start edge, product=16'h000F, ovf=0.
REQ-032 Test: M=-128, Q=-128 -> product=16'h4000, ovf=1.
REQ-033 Test: M=-1, Q=1 -> product=16'hFFFF, ovf=0; then M=127, Q=-128 -> product=16'hC080, ovf=1.
REQ-034 Test: start M=2, Q=3, then during RUN pulse start with M=9, Q=9 -> product=16'h0006, exactly one ready pulse.
REQ-035 Test: reset asserted 4 cycles into RUN -> no ready pulse, product=0, busy=0; a new start of 7*-6 -> product=16'hFFD6.
REQ-036 Test: 200 random signed operand pairs issued back-to-back -> each product equals the signed reference product, and ovf matches REQ-018.
